rv_core_ctrl: RTL and testbench
===============================

# rv_core_ctrl

Multi-cycle sequencer for the RV32I core. It owns the program counter and fetches each instruction over an OBI-style request/grant/valid bus. It holds the instruction stable for the decoder and steps the datapath through execute, optional data-memory access and register write-back. It is the only block that qualifies register-file writes and PC updates, so one instruction is in flight at a time.

## Interface
Parameters:
- BOOT_ADDR, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  core clock; all state changes on the rising edge.
- rst_ni  in  1  reset; asynchronous assert and active-low.
- instr_req_o  out  1  fetch request.
- instr_addr_o  out  32  fetch address; equals pc_o.
- instr_gnt_i  in  1  fetch request accepted.
- instr_rvalid_i  in  1  fetch data valid.
- instr_rdata_i  in  32  fetched instruction.
- instr_o  out  32  latched instruction to the decoder.
- instr_valid_o  out  1  high in EXECUTE only.
- pc_set_i  in  1  branch/jump taken; sampled in EXECUTE.
- pc_target_i  in  32  branch/jump target; sampled in EXECUTE.
- data_req_o  out  1  load/store request.
- data_we_o  out  1  high when the request is a store.
- data_gnt_i  in  1  data request accepted.
- data_rvalid_i  in  1  load data valid or store complete.
- rf_we_o  out  1  register-file write strobe.
- pc_o  out  32  current PC.
- retire_o  out  1  one-cycle pulse per completed instruction.
- instret_o  out  32  retired-instruction count.
- trap_o  out  1  sticky fault flag.

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, TRAP.
- IDLE: reset state; always goes to FETCH_REQ on the next edge.
- FETCH_REQ: instr_req_o=1 with instr_addr_o=pc_o, both held stable until instr_gnt_i; on grant go to FETCH_WAIT.
- FETCH_WAIT: instr_req_o=0; on instr_rvalid_i, latch instr_rdata_i into instr_o.
  - If instr_rdata_i[1:0]!=2'b11, go to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE: lasts exactly one cycle with instr_valid_o=1.
  - Compute next_pc = pc_set_i ? pc_target_i : pc_o+4, with 32-bit wrap.
  - If pc_set_i=1 and pc_target_i[1:0]!=0, go to TRAP.
  - Opcode instr_o[6:0]=7'b0000011 (LOAD) or 7'b0100011 (STORE) goes to MEM_REQ; any other opcode goes to WRITEBACK.
- MEM_REQ: data_req_o=1 with data_we_o=(opcode==STORE), held until data_gnt_i; then go to MEM_WAIT.
- MEM_WAIT: on data_rvalid_i, go to WRITEBACK.
- WRITEBACK: lasts one cycle.
  - rf_we_o=1 unless opcode is STORE or BRANCH (7'b1100011), or instr_o[11:7]==0.
  - pc_o <= next_pc, retire_o=1, instret_o increments with wrap at 2^32.
  - Next state is FETCH_REQ.
- TRAP: terminal.
  - trap_o=1; every request, strobe and retire output is 0.
  - pc_o and instr_o hold the values from the faulting instruction.
  - Only reset exits TRAP.
- instr_rvalid_i outside FETCH_WAIT and data_rvalid_i outside MEM_WAIT are ignored.
- Grant and valid arriving in the same cycle are not supported: valid is consumed only in the WAIT state after the grant.

## Timing
- Reset values:
  - State IDLE; pc_o=BOOT_ADDR; instr_o=32'h0000_0013 (NOP).
  - instret_o=0.
  - All request, strobe, valid, retire and trap outputs are 0.
- Control outputs decode from the state register only; no combinational path from any input to any output.
- Latency, with a grant in the first request cycle and the valid one cycle later:
  - ALU/branch instruction: 5 cycles from FETCH_REQ entry to the next FETCH_REQ entry.
  - Load/store: 7 cycles.
  - Each grant or valid wait cycle adds one cycle.
- pc_o changes only on the WRITEBACK edge, so instr_addr_o is stable for the entire fetch.
- Reset asserted mid-operation returns every output to its reset value immediately.
  - Outstanding bus transactions are abandoned.
  - The memories must be reset together with the core.

## Test plan
- Reset release with BOOT_ADDR=32'h100 and instr_gnt_i held 0 for 3 cycles -> instr_req_o stays 1 with addr 0x100 for all 3 cycles and drops the cycle after the grant.
- Fetch 32'h00500093 (addi x1,x0,5), grant immediate, valid next cycle -> instr_valid_o for 1 cycle, rf_we_o for 1 cycle, pc_o becomes 0x104, instret_o=1, 5 cycles in total.
- Fetch 32'h0000A103 (lw x2,0(x1)) with data_gnt_i delayed 2 cycles -> data_req_o=1 and data_we_o=0 held for 3 cycles, rf_we_o after data_rvalid_i, 9 cycles in total.
- Store 32'h0020A023, then a branch with pc_set_i=1 and pc_target_i=0x200 -> no rf_we_o on either instruction, data_we_o=1 on the store, pc_o=0x200 after the branch.
- Fetched word 32'h00000000 -> trap_o=1 and stays high, no further instr_req_o; async reset clears it.
- Taken branch with pc_target_i=0x202 -> TRAP from EXECUTE, no retire_o pulse; pc_o wrap from 0xFFFFFFFC with a non-branch instruction -> pc_o becomes 0.

Source files
------------

// File: rtl/rv_core_ctrl.sv
// Multi-cycle fetch/execute/memory/write-back sequencer for the RV32I core.
// It owns the PC and retire counter and is the only block that qualifies register and PC updates.
module rv_core_ctrl #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   input  logic        pc_set_i,
   input  logic [31:0] pc_target_i,
   output logic        data_req_o,
   output logic        data_we_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   output logic        rf_we_o,
   output logic [31:0] pc_o,
   output logic        retire_o,
   output logic [31:0] instret_o,
   output logic        trap_o
);

   typedef enum logic [2:0] {
      IDLE, FETCH_REQ, FETCH_WAIT, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, TRAP
   } state_e;

   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] next_pc_q;
   logic [31:0] instr_q;
   logic [31:0] instret_q;

   logic [31:0] next_pc_d;
   logic        bad_target_d;
   logic [6:0]  opcode;
   logic        is_mem;
   logic        is_store;
   logic        writes_rd;

   assign opcode    = instr_q[6:0];
   assign is_store  = (opcode == OPC_STORE);
   assign is_mem    = (opcode == OPC_LOAD) || is_store;
   assign writes_rd = !is_store && (opcode != OPC_BRANCH) && (instr_q[11:7] != 5'd0);

   always_comb begin
      next_pc_d    = pc_set_i ? pc_target_i : pc_q + 32'd4;
      bad_target_d = pc_set_i && (pc_target_i[1:0] != 2'b00);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: every register, including the latched instruction, is reset so an
      // abandoned bus transaction cannot leave stale state behind.
      if (!rst_ni) begin
         state_q   <= IDLE;
         pc_q      <= BOOT_ADDR;
         next_pc_q <= BOOT_ADDR;
         instr_q   <= NOP;
         instret_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE:       state_q <= FETCH_REQ;
            FETCH_REQ:  if (instr_gnt_i) state_q <= FETCH_WAIT;
            FETCH_WAIT: begin
               if (instr_rvalid_i) begin
                  instr_q <= instr_rdata_i;
                  state_q <= (instr_rdata_i[1:0] != 2'b11) ? TRAP : EXECUTE;
               end
            end
            EXECUTE: begin
               next_pc_q <= next_pc_d;
               if (bad_target_d)  state_q <= TRAP;
               else if (is_mem)   state_q <= MEM_REQ;
               else               state_q <= WRITEBACK;
            end
            MEM_REQ:    if (data_gnt_i) state_q <= MEM_WAIT;
            MEM_WAIT:   if (data_rvalid_i) state_q <= WRITEBACK;
            WRITEBACK: begin
               pc_q      <= next_pc_q;
               instret_q <= instret_q + 32'd1;
               state_q   <= FETCH_REQ;
            end
            TRAP:       state_q <= TRAP;
            default:    state_q <= TRAP;
         endcase
      end
   end

   // Outputs decode from registered state only; no input-to-output path.
   assign instr_req_o   = (state_q == FETCH_REQ);
   assign instr_addr_o  = pc_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = (state_q == EXECUTE);
   assign data_req_o    = (state_q == MEM_REQ);
   assign data_we_o     = (state_q == MEM_REQ) && is_store;
   assign rf_we_o       = (state_q == WRITEBACK) && writes_rd;
   assign retire_o      = (state_q == WRITEBACK);
   assign pc_o          = pc_q;
   assign instret_o     = instret_q;
   assign trap_o        = (state_q == TRAP);

endmodule

// File: tb/tb_rv_core_ctrl.sv
// Directed bench for rv_core_ctrl: a vector table of single instructions driven through
// a bus model, plus hand sequences for traps and asynchronous reset.
module tb_rv_core_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        pc_set_i;
   logic [31:0] pc_target_i;
   logic        data_req_o;
   logic        data_we_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic        rf_we_o;
   logic [31:0] pc_o;
   logic        retire_o;
   logic [31:0] instret_o;
   logic        trap_o;

   rv_core_ctrl #(.BOOT_ADDR(32'h0000_0100)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
      .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
      .pc_set_i(pc_set_i), .pc_target_i(pc_target_i),
      .data_req_o(data_req_o), .data_we_o(data_we_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
      .rf_we_o(rf_we_o), .pc_o(pc_o), .retire_o(retire_o),
      .instret_o(instret_o), .trap_o(trap_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] instr;
      logic        pc_set;
      logic [31:0] target;
      int          gnt_dly;
      int          dgnt_dly;
      logic [31:0] pc;
      logic        mem;
      logic        we;
      logic        rf;
      logic [1:0]  trap;     // 0 none, 1 fetch trap, 2 execute trap
      logic [31:0] npc;
      int          cycles;   // FETCH_REQ entry to next FETCH_REQ entry, both counted
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_instret = 32'd0;
   vec_t        vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      pc_set_i       = 1'b0;
      pc_target_i    = 32'h0;
      data_gnt_i     = 1'b0;
      data_rvalid_i  = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_req",     {31'd0, instr_req_o},   32'd0);
      check("rst_valid",   {31'd0, instr_valid_o}, 32'd0);
      check("rst_dreq",    {31'd0, data_req_o},    32'd0);
      check("rst_dwe",     {31'd0, data_we_o},     32'd0);
      check("rst_rfwe",    {31'd0, rf_we_o},       32'd0);
      check("rst_retire",  {31'd0, retire_o},      32'd0);
      check("rst_trap",    {31'd0, trap_o},        32'd0);
      check("rst_pc",      pc_o,                   32'h0000_0100);
      check("rst_addr",    instr_addr_o,           32'h0000_0100);
      check("rst_instr",   instr_o,                32'h0000_0013);
      check("rst_instret", instret_o,              32'd0);
   endtask

   // Asserts reset, checks reset values, releases at a falling edge; returns in FETCH_REQ.
   task automatic do_reset();
      rst_ni = 1'b0;
      idle_inputs();
      #1;
      check_reset_values();
      exp_instret = 32'd0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   // Drives one instruction from FETCH_REQ; inputs change and outputs are sampled at falling edges.
   task automatic run_vec(input vec_t v, input int idx);
      int cyc = 1;
      for (int k = 0; k <= v.gnt_dly; k++) begin
         check($sformatf("v%0d_fetch_req", idx), {31'd0, instr_req_o}, 32'd1);
         check($sformatf("v%0d_fetch_addr", idx), instr_addr_o, v.pc);
         instr_gnt_i    = (k == v.gnt_dly);
         instr_rvalid_i = (k != v.gnt_dly);   // stray valid before grant must be ignored
         instr_rdata_i  = 32'h0;
         @(negedge clk_i); cyc++;
      end
      instr_gnt_i = 1'b0;
      check($sformatf("v%0d_wait_req", idx), {31'd0, instr_req_o}, 32'd0);
      check($sformatf("v%0d_wait_valid", idx), {31'd0, instr_valid_o}, 32'd0);
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = v.instr;
      @(negedge clk_i); cyc++;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      if (v.trap == 2'd1) begin
         check($sformatf("v%0d_ftrap", idx), {31'd0, trap_o}, 32'd1);
         check($sformatf("v%0d_ftrap_instr", idx), instr_o, v.instr);
         check($sformatf("v%0d_ftrap_valid", idx), {31'd0, instr_valid_o}, 32'd0);
         return;
      end
      check($sformatf("v%0d_ex_valid", idx), {31'd0, instr_valid_o}, 32'd1);
      check($sformatf("v%0d_ex_instr", idx), instr_o, v.instr);
      check($sformatf("v%0d_ex_pc", idx), pc_o, v.pc);
      pc_set_i    = v.pc_set;
      pc_target_i = v.target;
      @(negedge clk_i); cyc++;
      pc_set_i    = 1'b0;
      pc_target_i = 32'h0;
      if (v.trap == 2'd2) begin
         check($sformatf("v%0d_xtrap", idx), {31'd0, trap_o}, 32'd1);
         check($sformatf("v%0d_xtrap_retire", idx), {31'd0, retire_o}, 32'd0);
         check($sformatf("v%0d_xtrap_pc", idx), pc_o, v.pc);
         return;
      end
      check($sformatf("v%0d_valid_1cyc", idx), {31'd0, instr_valid_o}, 32'd0);
      if (v.mem) begin
         for (int k = 0; k <= v.dgnt_dly; k++) begin
            check($sformatf("v%0d_dreq", idx), {31'd0, data_req_o}, 32'd1);
            check($sformatf("v%0d_dwe", idx), {31'd0, data_we_o}, {31'd0, v.we});
            check($sformatf("v%0d_mem_rfwe", idx), {31'd0, rf_we_o}, 32'd0);
            data_gnt_i    = (k == v.dgnt_dly);
            data_rvalid_i = (k != v.dgnt_dly);
            @(negedge clk_i); cyc++;
         end
         data_gnt_i = 1'b0;
         check($sformatf("v%0d_dwait_req", idx), {31'd0, data_req_o}, 32'd0);
         check($sformatf("v%0d_dwait_rfwe", idx), {31'd0, rf_we_o}, 32'd0);
         data_rvalid_i = 1'b1;
         @(negedge clk_i); cyc++;
         data_rvalid_i = 1'b0;
      end
      check($sformatf("v%0d_wb_dreq", idx), {31'd0, data_req_o}, 32'd0);
      check($sformatf("v%0d_wb_rfwe", idx), {31'd0, rf_we_o}, {31'd0, v.rf});
      check($sformatf("v%0d_wb_retire", idx), {31'd0, retire_o}, 32'd1);
      check($sformatf("v%0d_wb_pc_held", idx), pc_o, v.pc);
      @(negedge clk_i); cyc++;
      exp_instret = exp_instret + 32'd1;
      check($sformatf("v%0d_nx_retire", idx), {31'd0, retire_o}, 32'd0);
      check($sformatf("v%0d_nx_rfwe", idx), {31'd0, rf_we_o}, 32'd0);
      check($sformatf("v%0d_nx_pc", idx), pc_o, v.npc);
      check($sformatf("v%0d_nx_instret", idx), instret_o, exp_instret);
      check($sformatf("v%0d_nx_req", idx), {31'd0, instr_req_o}, 32'd1);
      check($sformatf("v%0d_cycles", idx), cyc, v.cycles);
   endtask

   task automatic check_trap_holds(input string name, input logic [31:0] pc, input logic [31:0] ins);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         check({name, "_trap"},   {31'd0, trap_o},      32'd1);
         check({name, "_req"},    {31'd0, instr_req_o}, 32'd0);
         check({name, "_dreq"},   {31'd0, data_req_o},  32'd0);
         check({name, "_retire"}, {31'd0, retire_o},    32'd0);
         check({name, "_rfwe"},   {31'd0, rf_we_o},     32'd0);
         check({name, "_pc"},     pc_o,                 pc);
         check({name, "_instr"},  instr_o,              ins);
         check({name, "_instret"}, instret_o,           exp_instret);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      //            instr          set   target        gd dd pc             mem   we    rf    trap  npc            cyc
      vecs[0] = '{32'h00500093, 1'b0, 32'h0,         3, 0, 32'h00000100, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00000104, 8};
      vecs[1] = '{32'h00500093, 1'b0, 32'h0,         0, 0, 32'h00000104, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00000108, 5};
      vecs[2] = '{32'h0000A103, 1'b0, 32'h0,         0, 2, 32'h00000108, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000010C, 9};
      vecs[3] = '{32'h0020A023, 1'b0, 32'h0,         0, 0, 32'h0000010C, 1'b1, 1'b1, 1'b0, 2'd0, 32'h00000110, 7};
      vecs[4] = '{32'h00000463, 1'b1, 32'h00000200,  0, 0, 32'h00000110, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00000200, 5};
      vecs[5] = '{32'h000000EF, 1'b1, 32'hFFFFFFFC,  0, 0, 32'h00000200, 1'b0, 1'b0, 1'b1, 2'd0, 32'hFFFFFFFC, 5};
      vecs[6] = '{32'h00000013, 1'b0, 32'h0,         0, 0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00000000, 5};
      vecs[7] = '{32'h002081B3, 1'b0, 32'h0,         1, 0, 32'h00000000, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00000004, 6};

      idle_inputs();
      rst_ni = 1'b1;
      #2;
      do_reset();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Misaligned taken-branch target traps from EXECUTE without retiring.
      run_vec('{32'h00000463, 1'b1, 32'h00000202, 0, 0, 32'h00000004, 1'b0, 1'b0, 1'b0, 2'd2,
                32'h0, 0}, 8);
      check_trap_holds("xtrap_hold", 32'h00000004, 32'h00000463);

      do_reset();

      // All-zero fetched word is not a 32-bit encoding and traps from FETCH_WAIT.
      run_vec('{32'h00000000, 1'b0, 32'h0, 0, 0, 32'h00000100, 1'b0, 1'b0, 1'b0, 2'd1,
                32'h0, 0}, 9);
      check_trap_holds("ftrap_hold", 32'h00000100, 32'h00000000);

      do_reset();

      // Asynchronous reset in the middle of a fetch, between clock edges.
      instr_gnt_i = 1'b1;
      @(negedge clk_i);
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'h00500093;
      @(negedge clk_i);
      check("midrst_pre_valid", {31'd0, instr_valid_o}, 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_reset_values();
      idle_inputs();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      exp_instret = 32'd0;
      run_vec(vecs[1].pc == 32'h104 ?
              '{32'h00500093, 1'b0, 32'h0, 0, 0, 32'h00000100, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00000104, 5} :
              vecs[1], 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
